// File: rtl/mc_controller_if.sv
// Control/status bundle between the multicycle MIPS controller (master) and its datapath (slave).
interface mc_controller_if #(
    parameter int ALUCTL_W = 3
) ();
    logic [5:0]          op;
    logic [5:0]          funct;
    logic                zero;
    logic                memready;
    logic                pcen;
    logic                irwrite;
    logic                memwrite;
    logic                regwrite;
    logic                iord;
    logic                alusrca;
    logic [1:0]          alusrcb;
    logic                immzero;
    logic                regdst;
    logic                memtoreg;
    logic [1:0]          pcsrc;
    logic [ALUCTL_W-1:0] alucontrol;
    logic                illegal_op;
    logic [3:0]          state;

    modport master (
        input  op, funct, zero, memready,
        output pcen, irwrite, memwrite, regwrite, iord, alusrca, alusrcb,
               immzero, regdst, memtoreg, pcsrc, alucontrol, illegal_op, state
    );

    modport slave (
        output op, funct, zero, memready,
        input  pcen, irwrite, memwrite, regwrite, iord, alusrca, alusrcb,
               immzero, regdst, memtoreg, pcsrc, alucontrol, illegal_op, state
    );
endinterface

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing each instruction over 3-5 cycles
// on a shared memory and ALU, with optional memory-ready stalls.
module mc_controller #(
    parameter int ALUCTL_W = 3,
    parameter bit EN_BNE   = 1'b1,
    parameter bit EN_LOGI  = 1'b1,
    parameter bit MEM_WAIT = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    mc_controller_if.master bus
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        RTEX   = 4'd6,
        RTWB   = 4'd7,
        BREX   = 4'd8,
        ITEX   = 4'd9,
        ITWB   = 4'd10,
        JEX    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [ALUCTL_W-1:0] ALU_AND = ALUCTL_W'(3'b000);
    localparam logic [ALUCTL_W-1:0] ALU_OR  = ALUCTL_W'(3'b001);
    localparam logic [ALUCTL_W-1:0] ALU_ADD = ALUCTL_W'(3'b010);
    localparam logic [ALUCTL_W-1:0] ALU_SUB = ALUCTL_W'(3'b110);
    localparam logic [ALUCTL_W-1:0] ALU_SLT = ALUCTL_W'(3'b111);

    state_t state_q, state_d;

    logic mem_rdy;
    logic is_rtype, is_lw, is_sw, is_beq, is_bne, is_addi, is_andi, is_ori, is_j, is_legal;

    logic                pcen, irwrite, memwrite, regwrite, iord, alusrca;
    logic [1:0]          alusrcb;
    logic                immzero, regdst, memtoreg;
    logic [1:0]          pcsrc;
    logic [ALUCTL_W-1:0] alucontrol;
    logic                illegal_op;

    // Without memory wait support every memory access is assumed to complete immediately.
    assign mem_rdy  = MEM_WAIT ? bus.memready : 1'b1;

    assign is_rtype = (bus.op == OP_RTYPE);
    assign is_lw    = (bus.op == OP_LW);
    assign is_sw    = (bus.op == OP_SW);
    assign is_beq   = (bus.op == OP_BEQ);
    assign is_bne   = EN_BNE && (bus.op == OP_BNE);
    assign is_addi  = (bus.op == OP_ADDI);
    assign is_andi  = EN_LOGI && (bus.op == OP_ANDI);
    assign is_ori   = EN_LOGI && (bus.op == OP_ORI);
    assign is_j     = (bus.op == OP_J);
    assign is_legal = is_rtype | is_lw | is_sw | is_beq | is_bne |
                      is_addi | is_andi | is_ori | is_j;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  if (mem_rdy) state_d = DECODE;
            DECODE: begin
                if (is_lw || is_sw)                   state_d = MEMADR;
                else if (is_rtype)                    state_d = RTEX;
                else if (is_beq || is_bne)            state_d = BREX;
                else if (is_addi || is_andi || is_ori) state_d = ITEX;
                else if (is_j)                        state_d = JEX;
                else                                  state_d = FETCH;
            end
            MEMADR: state_d = is_lw ? MEMRD : (is_sw ? MEMWR : FETCH);
            MEMRD:  if (mem_rdy) state_d = MEMWB;
            MEMWR:  if (mem_rdy) state_d = FETCH;
            RTEX:   state_d = RTWB;
            ITEX:   state_d = ITWB;
            MEMWB, RTWB, BREX, ITWB, JEX: state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        pcen       = 1'b0;
        irwrite    = 1'b0;
        memwrite   = 1'b0;
        regwrite   = 1'b0;
        iord       = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        immzero    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        pcsrc      = 2'b00;
        alucontrol = ALU_ADD;
        illegal_op = 1'b0;
        case (state_q)
            FETCH: begin
                alusrcb = 2'b01;
                irwrite = mem_rdy;
                pcen    = mem_rdy;
            end
            DECODE: begin
                alusrcb    = 2'b11;
                illegal_op = !is_legal;
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: iord = 1'b1;
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            RTEX: begin
                alusrca = 1'b1;
                case (bus.funct)
                    6'b100010: alucontrol = ALU_SUB;
                    6'b100100: alucontrol = ALU_AND;
                    6'b100101: alucontrol = ALU_OR;
                    6'b101010: alucontrol = ALU_SLT;
                    default:   alucontrol = ALU_ADD;
                endcase
            end
            RTWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BREX: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                pcen       = is_bne ? !bus.zero : bus.zero;
            end
            ITEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                immzero = is_andi | is_ori;
                if (is_andi)     alucontrol = ALU_AND;
                else if (is_ori) alucontrol = ALU_OR;
                else             alucontrol = ALU_ADD;
            end
            ITWB: regwrite = 1'b1;
            JEX: begin
                pcsrc = 2'b10;
                pcen  = 1'b1;
            end
            default: ;
        endcase
        // While reset is held no write strobe may escape, even though FETCH is showing.
        if (!reset_n) begin
            pcen       = 1'b0;
            irwrite    = 1'b0;
            memwrite   = 1'b0;
            regwrite   = 1'b0;
            illegal_op = 1'b0;
        end
    end

    assign bus.pcen       = pcen;
    assign bus.irwrite    = irwrite;
    assign bus.memwrite   = memwrite;
    assign bus.regwrite   = regwrite;
    assign bus.iord       = iord;
    assign bus.alusrca    = alusrca;
    assign bus.alusrcb    = alusrcb;
    assign bus.immzero    = immzero;
    assign bus.regdst     = regdst;
    assign bus.memtoreg   = memtoreg;
    assign bus.pcsrc      = pcsrc;
    assign bus.alucontrol = alucontrol;
    assign bus.illegal_op = illegal_op;
    assign bus.state      = state_q;
endmodule
